// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises 10-bit command frames from MOSI and
// serialises one byte of read data onto MISO after a read-data command.
// The system clock doubles as the SPI serial clock; everything runs on its
// rising edge.
module spi_slave_if #(
    parameter logic MISO_IDLE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SS_n,
    input  logic       MOSI,
    output logic       MISO,
    output logic [9:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid
);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    // Body counter reaching this value marks a fully received frame; the
    // FSM then parks in its state until SS_n rises.
    localparam logic [3:0] BODY_LAST = 4'd8;
    localparam logic [3:0] BODY_DONE = 4'd9;
    localparam logic [3:0] TX_BITS   = 4'd8;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  bit_cnt;
    logic [8:0]  rx_shift;
    logic        rd_addr_seen;
    logic [7:0]  tx_reg;
    logic [3:0]  tx_cnt;
    logic        tx_busy;
    logic        tx_done;

    logic        in_body;
    logic        last_bit;
    logic        data_wait;
    logic        tx_load;

    // Frame-phase decode shared by the FSM and the datapath.
    always_comb begin
        in_body   = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
        // SS_n high while bit 0 is sampled is an abort, so it never completes a frame.
        last_bit  = in_body && !SS_n && (bit_cnt == BODY_LAST);
        // Data-wait: read-data frame complete, no byte launched yet.
        data_wait = (state == READ_DATA) && (bit_cnt == BODY_DONE) && !tx_busy && !tx_done;
        tx_load   = data_wait && tx_valid && !SS_n;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; SS_n high drops any active frame back to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!SS_n) begin
                    state_nxt = CHK_CMD;
                end
            end
            CHK_CMD: begin
                if (SS_n) begin
                    state_nxt = IDLE;
                end else if (!MOSI) begin
                    state_nxt = WRITE;
                end else if (rd_addr_seen) begin
                    state_nxt = READ_DATA;
                end else begin
                    state_nxt = READ_ADD;
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (SS_n) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Receive shifting, frame strobe, read-address tracking and MISO serialiser.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt      <= 4'd0;
            rx_shift     <= 9'd0;
            rx_data      <= 10'h000;
            rx_valid     <= 1'b0;
            rd_addr_seen <= 1'b0;
            tx_reg       <= 8'h00;
            tx_cnt       <= 4'd0;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
            MISO         <= MISO_IDLE;
        end else begin
            rx_valid <= 1'b0;
            if (SS_n || (state == IDLE)) begin
                // Idle or abort: drop partial progress, keep rd_addr_seen.
                bit_cnt <= 4'd0;
                tx_cnt  <= 4'd0;
                tx_busy <= 1'b0;
                tx_done <= 1'b0;
                MISO    <= MISO_IDLE;
            end else if (state == CHK_CMD) begin
                rx_shift <= {rx_shift[7:0], MOSI};
                bit_cnt  <= 4'd0;
            end else begin
                if (bit_cnt != BODY_DONE) begin
                    rx_shift <= {rx_shift[7:0], MOSI};
                    bit_cnt  <= bit_cnt + 4'd1;
                end
                if (last_bit) begin
                    rx_data  <= {rx_shift, MOSI};
                    rx_valid <= 1'b1;
                    if (state == READ_ADD) begin
                        rd_addr_seen <= 1'b1;
                    end else if (state == READ_DATA) begin
                        rd_addr_seen <= 1'b0;
                    end
                end
                if (tx_load) begin
                    // MSB goes out straight away so it appears the cycle after tx_valid.
                    tx_reg  <= tx_data;
                    MISO    <= tx_data[7];
                    tx_cnt  <= 4'd1;
                    tx_busy <= 1'b1;
                end else if (tx_busy) begin
                    if (tx_cnt == TX_BITS) begin
                        MISO    <= MISO_IDLE;
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                    end else begin
                        MISO   <= tx_reg[3'd7 - tx_cnt[2:0]];
                        tx_cnt <= tx_cnt + 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/spi_slave_if.md
SPI_SLAVE_IF -- requirements
Module: spi_slave_if

Interface
REQ-001 The module SHALL have one parameter: MISO_IDLE, default 1'b0, the level driven on MISO whenever no read data is being shifted.
REQ-002 The module SHALL have these ports, listed as name, direction, width, meaning:
- clk  input  1  single clock, used as the SPI serial clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- SS_n  input  1  active-low slave select; a frame is active while it is 0.
- MOSI  input  1  serial data in, MSB first.
- MISO  output  1  serial data out, MSB first.
- rx_data  output  10  received frame: [9:8] command, [7:0] address or data.
- rx_valid  output  1  one-cycle strobe qualifying rx_data.
- tx_data  input  8  read data returned by the memory.
- tx_valid  input  1  qualifies tx_data.
REQ-003 All outputs SHALL be registered.

Function
REQ-010 The FSM SHALL have the states IDLE, CHK_CMD, WRITE, READ_ADD and READ_DATA, plus an internal rd_addr_seen flag.
REQ-011 In IDLE: SS_n=0 SHALL go to CHK_CMD; otherwise stay in IDLE.
REQ-012 In CHK_CMD, MOSI is frame bit 9 and SHALL be shifted into the receive register.
- Next state: WRITE if MOSI=0.
- READ_ADD if MOSI=1 and rd_addr_seen=0.
- READ_DATA if MOSI=1 and rd_addr_seen=1.
REQ-013 In WRITE, READ_ADD and READ_DATA, the next 9 cycles SHALL each shift one MOSI bit into the receive register (bit 8 down to bit 0), using a 4-bit counter.
REQ-014 In the cycle after bit 0 is sampled, rx_data SHALL hold the 10 sampled bits and rx_valid SHALL be 1 for exactly one cycle.
- rx_data SHALL hold its value until the next completed frame.
REQ-015 Latency: rx_valid SHALL rise 10 cycles after the CHK_CMD cycle.
REQ-016 The frame SHALL be forwarded unaltered; bit 8 is not checked by the slave.
REQ-017 After a WRITE frame completes, the FSM SHALL remain in WRITE, ignoring MOSI, until SS_n=1.
REQ-018 A completed READ_ADD frame SHALL set rd_addr_seen=1; the FSM then waits in READ_ADD for SS_n=1.
REQ-019 A completed READ_DATA frame SHALL clear rd_addr_seen=0 and enter the data-wait phase.
REQ-020 In the data-wait phase, the first cycle with tx_valid=1 SHALL latch tx_data into the transmit register.
- MISO SHALL then carry tx_data[7] in the next cycle, followed by [6] through [0] on the following cycles (8 cycles total).
- MISO SHALL then return to MISO_IDLE.
REQ-021 tx_valid SHALL be ignored outside the data-wait phase; extra tx_valid pulses during or after shifting SHALL be ignored.
REQ-022 SS_n=1 in any non-IDLE state SHALL move the FSM to IDLE on the next edge.
- This clears the counter and aborts any shift.
- No rx_valid SHALL be generated for a partial frame.
- MISO SHALL be forced to MISO_IDLE.
- rd_addr_seen SHALL be unchanged.
REQ-023 SS_n rising in the same cycle that bit 0 is sampled SHALL count as an abort (no rx_valid).
REQ-024 A new frame SHALL require at least one cycle in IDLE (SS_n=1).

Reset
REQ-030 rst=1 at a clock edge SHALL set, from any state including mid-frame:
- state=IDLE, counter=0, rd_addr_seen=0
- rx_data=10'h000, rx_valid=0
- MISO=MISO_IDLE
- transmit register=8'h00

Verification
REQ-040 Write address: SS_n=0, MOSI=00_1010_0101 -> single rx_valid pulse with rx_data=10'h0A5, 10 cycles after CHK_CMD.
REQ-041 Write data: frame 01_0011_1100 -> rx_data=10'h13C, one-cycle rx_valid.
REQ-042 Read sequence:
- Frame 10_0000_0101 -> rx_data=10'h205 and rd_addr_seen=1.
- Next frame 11_0000_0000 -> rx_data=10'h300.
- tx_valid with tx_data=8'hC3 two cycles later -> MISO shows 1,1,0,0,0,0,1,1 on the next 8 cycles, then MISO_IDLE.
REQ-043 Abort: SS_n=1 after 5 bits -> no rx_valid, IDLE next cycle; a following full frame decodes correctly.
REQ-044 Reset mid-shift: rst=1 during the 3rd MISO bit -> MISO=MISO_IDLE, rd_addr_seen=0; the next 11-prefixed frame goes to READ_ADD.
REQ-045 Spurious tx_valid in IDLE or WRITE -> MISO stays MISO_IDLE.
